piso_4bit_tx: RTL and testbench
===============================

Name: piso_4bit_tx

Overview:
- Parallel-in serial-out transmitter. It is the transmit end of the serial link whose receive end is the existing 4-bit SIPO deserializer.
- Accepts a WIDTH-bit word through a valid/ready load handshake, then shifts it out one bit per clock.
- Provides serial valid and framing strobes so a downstream SIPO can capture the word.
- Sits between a parallel data source (register or FIFO) and the serial line.

Parameters:
- WIDTH, 4, word width in bits (≥2).
- MSB_FIRST, 1, 1 = transmit pin[WIDTH-1] first; 0 = transmit pin[0] first.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- load_valid  input  1  source presents a word on pin.
- pin  input  WIDTH  parallel word to transmit.
- load_ready  output  1  block can accept a word this cycle.
- sout  output  1  serial data bit.
- sout_valid  output  1  sout carries a frame bit.
- frame_start  output  1  one-cycle strobe with the first bit of a frame.
- frame_done  output  1  one-cycle strobe with the last bit of a frame.

Behaviour:
- Reset (async, while rst=1):
  - State = IDLE; shift register = 0; bit counter = 0.
  - sout = 0, sout_valid = 0, frame_start = 0, frame_done = 0, load_ready = 1.
  - A load_valid asserted during reset is ignored.
- FSM states: IDLE, SHIFT.
- load_ready is combinational:
  - 1 in IDLE.
  - 1 in SHIFT only when counter = WIDTH-1 (last bit on the line).
  - 0 otherwise.
- Accept: load_valid & load_ready at a rising edge. pin is captured into the shift register at that same edge.
- Output registers (sout, sout_valid, frame_start, frame_done) all update on the clock edge.
- Latency: the first bit appears on sout in the cycle immediately after the accept edge.
- Frame length: exactly WIDTH consecutive cycles with sout_valid = 1, counter running 0..WIDTH-1.
- Bit order:
  - MSB_FIRST=1: pin[WIDTH-1] down to pin[0].
  - MSB_FIRST=0: pin[0] up to pin[WIDTH-1].
- frame_start = 1 when counter = 0 (first bit cycle). frame_done = 1 when counter = WIDTH-1 (last bit cycle).
- Transitions:
  - IDLE → SHIFT on accept; counter loads 0.
  - SHIFT, counter < WIDTH-1 → SHIFT; counter increments; register shifts by one.
  - SHIFT, counter = WIDTH-1, accept → SHIFT; counter = 0; new word loaded. This is back-to-back with no gap.
  - SHIFT, counter = WIDTH-1, no accept → IDLE.
- In IDLE: sout = 0, sout_valid = 0, strobes = 0.
- load_valid while load_ready = 0 is ignored. pin may change freely then. The source must hold load_valid until accepted.
- pin is sampled only at the accept edge. Later changes to pin do not affect the frame in flight.
- Reset mid-frame: the frame is aborted immediately (async), all outputs go to reset values, and transmission does not resume after reset release.
- Counter width: clog2(WIDTH) bits. The counter never exceeds WIDTH-1.

Test Plan:
- Reset/idle: assert rst for 12 ns, release, hold load_valid=0 for 5 cycles → sout=0, sout_valid=0, load_ready=1 throughout.
- Basic MSB-first frame (WIDTH=4, MSB_FIRST=1): load 4'b1011 for one cycle → next 4 cycles sout = 1,0,1,1 with sout_valid=1; frame_start in cycle 1, frame_done in cycle 4; load_ready=0 in cycles 1–3; return to IDLE.
- LSB-first (MSB_FIRST=0): load 4'b1011 → sout = 1,1,0,1.
- Back-to-back: hold load_valid=1 with 4'b1100, then present 4'b0011 during the last-bit cycle → 8 contiguous valid cycles, sout = 1,1,0,0,0,0,1,1; frame_done and frame_start adjacent; no idle gap.
- Busy load ignored: during cycle 2 of a 4'b1010 frame, pulse load_valid with 4'b0101 → frame completes as 1,0,1,0 and the 4'b0101 word is never transmitted.
- Reset mid-frame: assert rst asynchronously (not on a clock edge) in bit cycle 2 → sout, sout_valid, and strobes go to 0 immediately; after release the block stays IDLE with load_ready=1; a new load of 4'b0110 transmits correctly.

Source files
------------

// File: rtl/piso_4bit_tx.sv
// Parallel-in serial-out transmitter feeding the 4-bit SIPO deserializer.
// It accepts a word over a valid/ready handshake and shifts it out one bit per clock, with framing strobes.
module piso_4bit_tx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] pin,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             frame_done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;

  logic             accept;
  logic             first_bit;
  logic             next_bit;
  logic [WIDTH-1:0] load_rest;
  logic [WIDTH-1:0] shift_rest;

  // Ready during the last bit as well, so the next word can follow without an idle gap.
  assign load_ready = (state == IDLE) || (cnt == LAST);
  assign accept     = load_valid && load_ready;

  // The first bit goes straight to sout at the accept edge, and the register keeps the remaining bits.
  generate
    if (MSB_FIRST) begin : g_msb
      assign first_bit  = pin[WIDTH-1];
      assign load_rest  = {pin[WIDTH-2:0], 1'b0};
      assign next_bit   = shreg[WIDTH-1];
      assign shift_rest = {shreg[WIDTH-2:0], 1'b0};
    end else begin : g_lsb
      assign first_bit  = pin[0];
      assign load_rest  = {1'b0, pin[WIDTH-1:1]};
      assign next_bit   = shreg[0];
      assign shift_rest = {1'b0, shreg[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      shreg       <= '0;
      sout        <= 1'b0;
      sout_valid  <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state       <= SHIFT;
            cnt         <= '0;
            shreg       <= load_rest;
            sout        <= first_bit;
            sout_valid  <= 1'b1;
            frame_start <= 1'b1;
            frame_done  <= 1'b0;
          end
        end
        SHIFT: begin
          if (cnt != LAST) begin
            cnt         <= cnt + CW'(1);
            shreg       <= shift_rest;
            sout        <= next_bit;
            sout_valid  <= 1'b1;
            frame_start <= 1'b0;
            frame_done  <= (cnt == PENULT);
          end else if (accept) begin
            cnt         <= '0;
            shreg       <= load_rest;
            sout        <= first_bit;
            sout_valid  <= 1'b1;
            frame_start <= 1'b1;
            frame_done  <= 1'b0;
          end else begin
            state       <= IDLE;
            cnt         <= '0;
            shreg       <= '0;
            sout        <= 1'b0;
            sout_valid  <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_4bit_tx.sv
// Bench for piso_4bit_tx: MSB-first and LSB-first instances share the stimulus.
// A queue holds the expected serial bits, and the negedge monitor compares them.
module tb_piso_4bit_tx;

  logic       clk;
  logic       rst;
  logic       load_valid;
  logic [3:0] pin;

  logic ready_m, sout_m, valid_m, start_m, done_m;
  logic ready_l, sout_l, valid_l, start_l, done_l;

  piso_4bit_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .load_valid(load_valid), .pin(pin),
    .load_ready(ready_m), .sout(sout_m), .sout_valid(valid_m),
    .frame_start(start_m), .frame_done(done_m)
  );

  piso_4bit_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .load_valid(load_valid), .pin(pin),
    .load_ready(ready_l), .sout(sout_l), .sout_valid(valid_l),
    .frame_start(start_l), .frame_done(done_l)
  );

  typedef struct packed {
    logic [3:0] word;
    logic [3:0] msb_seq;
    logic [3:0] lsb_seq;
  } vec_t;

  typedef struct packed {
    logic m;
    logic l;
    logic first;
    logic last;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[9];
  int   total = 0;
  int   bad   = 0;
  exp_t mon_e;
  int   mon_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkIdleNow(input string tag);
    checkOutput({tag, "_sout_m"}, sout_m, 0);
    checkOutput({tag, "_valid_m"}, valid_m, 0);
    checkOutput({tag, "_start_m"}, start_m, 0);
    checkOutput({tag, "_done_m"}, done_m, 0);
    checkOutput({tag, "_ready_m"}, ready_m, 1);
    checkOutput({tag, "_sout_l"}, sout_l, 0);
    checkOutput({tag, "_valid_l"}, valid_l, 0);
    checkOutput({tag, "_start_l"}, start_l, 0);
    checkOutput({tag, "_done_l"}, done_l, 0);
    checkOutput({tag, "_ready_l"}, ready_l, 1);
  endtask

  // Sequences are written in transmit order, so bit 3 is the first bit on the line.
  task automatic pushFrame(input vec_t v);
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      e.m     = v.msb_seq[3-i];
      e.l     = v.lsb_seq[3-i];
      e.first = (i == 0);
      e.last  = (i == 3);
      sb.push_back(e);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    load_valid = 1'b1;
    pin        = v.word;
    @(posedge clk);
    #1;
    pushFrame(v);
    load_valid = 1'b0;
    pin        = 4'($urandom);
  endtask

  // The block must be ready whenever at most the last bit of a frame is still outstanding.
  always @(negedge clk) begin
    if (!rst) begin
      mon_ready = (sb.size() <= 1) ? 1 : 0;
      checkOutput("ready_m", ready_m, mon_ready);
      checkOutput("ready_l", ready_l, mon_ready);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        checkOutput("valid_m", valid_m, 1);
        checkOutput("valid_l", valid_l, 1);
        checkOutput("sout_m", sout_m, mon_e.m);
        checkOutput("sout_l", sout_l, mon_e.l);
        checkOutput("start_m", start_m, mon_e.first);
        checkOutput("start_l", start_l, mon_e.first);
        checkOutput("done_m", done_m, mon_e.last);
        checkOutput("done_l", done_l, mon_e.last);
      end else begin
        checkOutput("idle_valid_m", valid_m, 0);
        checkOutput("idle_valid_l", valid_l, 0);
        checkOutput("idle_sout_m", sout_m, 0);
        checkOutput("idle_sout_l", sout_l, 0);
        checkOutput("idle_start_m", start_m, 0);
        checkOutput("idle_start_l", start_l, 0);
        checkOutput("idle_done_m", done_m, 0);
        checkOutput("idle_done_l", done_l, 0);
      end
    end
  end

  initial begin
    vecs[0] = '{word: 4'b1011, msb_seq: 4'b1011, lsb_seq: 4'b1101};
    vecs[1] = '{word: 4'b0110, msb_seq: 4'b0110, lsb_seq: 4'b0110};
    vecs[2] = '{word: 4'b0001, msb_seq: 4'b0001, lsb_seq: 4'b1000};
    vecs[3] = '{word: 4'b1000, msb_seq: 4'b1000, lsb_seq: 4'b0001};
    vecs[4] = '{word: 4'b1111, msb_seq: 4'b1111, lsb_seq: 4'b1111};
    vecs[5] = '{word: 4'b0000, msb_seq: 4'b0000, lsb_seq: 4'b0000};
    vecs[6] = '{word: 4'b1100, msb_seq: 4'b1100, lsb_seq: 4'b0011};
    vecs[7] = '{word: 4'b0011, msb_seq: 4'b0011, lsb_seq: 4'b1100};
    vecs[8] = '{word: 4'b1010, msb_seq: 4'b1010, lsb_seq: 4'b0101};

    // A load offered while reset is held must leave no trace.
    rst        = 1'b1;
    load_valid = 1'b1;
    pin        = 4'hF;
    #2;
    checkIdleNow("reset");
    #9;
    load_valid = 1'b0;
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i]);
      repeat (4) @(posedge clk);
    end

    // Back-to-back: load_valid stays high, and the second word is presented in the last-bit cycle.
    @(negedge clk);
    load_valid = 1'b1;
    pin        = vecs[6].word;
    @(posedge clk);
    #1;
    pushFrame(vecs[6]);
    repeat (3) @(posedge clk);
    @(negedge clk);
    pin = vecs[7].word;
    @(posedge clk);
    #1;
    pushFrame(vecs[7]);
    load_valid = 1'b0;
    repeat (5) @(posedge clk);

    // A load pulsed while busy is dropped and is never transmitted.
    applyStimulus(vecs[8]);
    @(posedge clk);
    @(negedge clk);
    load_valid = 1'b1;
    pin        = 4'b0101;
    @(negedge clk);
    load_valid = 1'b0;
    repeat (4) @(posedge clk);

    // Asynchronous reset in bit cycle 2 aborts the frame, and transmission must not resume.
    applyStimulus(vecs[0]);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkIdleNow("midreset");
    sb.delete();
    #10;
    rst = 1'b0;
    #2;
    checkOutput("post_reset_ready_m", ready_m, 1);
    checkOutput("post_reset_ready_l", ready_l, 1);
    repeat (3) @(posedge clk);
    applyStimulus(vecs[1]);
    repeat (6) @(posedge clk);

    checkOutput("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
